// File: rtl/rob_ctrl.sv
// Re-order buffer controller: 16-entry circular ROB with dual allocate,
// triple completion and dual in-order retirement.
module rob_ctrl #(
  parameter int DEPTH = 16,
  parameter int PW    = 6
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     alloc_v_1,
  input  logic                     alloc_v_2,
  input  logic [PW-1:0]            alloc_pd_1,
  input  logic [PW-1:0]            alloc_pd_2,
  input  logic [PW-1:0]            alloc_opd_1,
  input  logic [PW-1:0]            alloc_opd_2,
  input  logic [4:0]               alloc_rd_1,
  input  logic [4:0]               alloc_rd_2,
  input  logic                     alloc_st_1,
  input  logic                     alloc_st_2,
  output logic                     alloc_ok,
  output logic [$clog2(DEPTH)-1:0] alloc_idx_1,
  output logic [$clog2(DEPTH)-1:0] alloc_idx_2,
  input  logic                     comp_v_1,
  input  logic                     comp_v_2,
  input  logic                     comp_v_3,
  input  logic [$clog2(DEPTH)-1:0] comp_idx_1,
  input  logic [$clog2(DEPTH)-1:0] comp_idx_2,
  input  logic [$clog2(DEPTH)-1:0] comp_idx_3,
  input  logic [31:0]              comp_res_1,
  input  logic [31:0]              comp_res_2,
  input  logic [31:0]              comp_res_3,
  output logic                     rt_flag_1,
  output logic                     rt_flag_2,
  output logic [4:0]               rt_index_1,
  output logic [4:0]               rt_index_2,
  output logic [31:0]              rt_result_1,
  output logic [31:0]              rt_result_2,
  output logic [PW-1:0]            fp_i_1,
  output logic [PW-1:0]            fp_i_2,
  output logic                     rt_store_1,
  output logic                     rt_store_2,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DEPTH-1:0] v_q;
  logic [DEPTH-1:0] comp_q;
  logic [DEPTH-1:0] st_q;
  logic [4:0]       rd_q  [DEPTH];
  logic [PW-1:0]    opd_q [DEPTH];
  logic [31:0]      res_q [DEPTH];

  logic [AW-1:0] head, tail;
  logic [AW-1:0] head_p1, tail_p1;
  logic [1:0]    n_req, n_alloc, n_ret;
  logic [CW-1:0] free_cnt;
  logic          ret_1, ret_2;
  logic          take_1, take_2;

  // The new physical register is tracked by rename; nothing retires it.
  logic unused_pd;
  assign unused_pd = ^{alloc_pd_1, alloc_pd_2};

  // NOTE: every signal driven in always_comb gets a default first so no
  // path leaves it unassigned; a missing default infers a latch.
  always_comb begin
    head_p1  = head + 1'b1;
    tail_p1  = tail + 1'b1;
    n_req    = {1'b0, alloc_v_1} + {1'b0, alloc_v_2};
    free_cnt = CW'(DEPTH) - count;
    alloc_ok = free_cnt >= CW'(n_req);
    take_1   = alloc_ok && alloc_v_1;
    take_2   = alloc_ok && alloc_v_2;
    n_alloc  = alloc_ok ? n_req : 2'd0;
    alloc_idx_1 = tail;
    alloc_idx_2 = (alloc_v_2 && !alloc_v_1) ? tail : tail_p1;
    // Retirement looks only at state registered at the start of the cycle.
    ret_1 = v_q[head] && comp_q[head];
    ret_2 = ret_1 && v_q[head_p1] && comp_q[head_p1];
    n_ret = {1'b0, ret_1} + {1'b0, ret_2};
    full  = count == CW'(DEPTH);
    empty = count == '0;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // read in this block sees the value from before the edge; later writes
  // to the same bit override earlier ones, which encodes the priorities.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      v_q    <= '0;
      comp_q <= '0;
      head   <= '0;
      tail   <= '0;
      count  <= '0;
    end else begin
      if (comp_v_3 && v_q[comp_idx_3]) comp_q[comp_idx_3] <= 1'b1;
      if (comp_v_2 && v_q[comp_idx_2]) comp_q[comp_idx_2] <= 1'b1;
      if (comp_v_1 && v_q[comp_idx_1]) comp_q[comp_idx_1] <= 1'b1;
      if (ret_1) begin
        v_q[head]    <= 1'b0;
        comp_q[head] <= 1'b0;
      end
      if (ret_2) begin
        v_q[head_p1]    <= 1'b0;
        comp_q[head_p1] <= 1'b0;
      end
      if (take_1) begin
        v_q[alloc_idx_1]    <= 1'b1;
        comp_q[alloc_idx_1] <= 1'b0;
      end
      if (take_2) begin
        v_q[alloc_idx_2]    <= 1'b1;
        comp_q[alloc_idx_2] <= 1'b0;
      end
      head  <= head + AW'(n_ret);
      tail  <= tail + AW'(n_alloc);
      count <= count + CW'(n_alloc) - CW'(n_ret);
    end
  end

  // NOTE: the payload arrays carry no reset; an entry's fields are only
  // ever read while its v bit is set, and v is always cleared on reset.
  always_ff @(posedge clk) begin
    if (take_1) begin
      st_q[alloc_idx_1]  <= alloc_st_1;
      rd_q[alloc_idx_1]  <= alloc_rd_1;
      opd_q[alloc_idx_1] <= alloc_opd_1;
    end
    if (take_2) begin
      st_q[alloc_idx_2]  <= alloc_st_2;
      rd_q[alloc_idx_2]  <= alloc_rd_2;
      opd_q[alloc_idx_2] <= alloc_opd_2;
    end
    // Port 1 is written last so it wins a same-index conflict.
    if (comp_v_3 && v_q[comp_idx_3]) res_q[comp_idx_3] <= comp_res_3;
    if (comp_v_2 && v_q[comp_idx_2]) res_q[comp_idx_2] <= comp_res_2;
    if (comp_v_1 && v_q[comp_idx_1]) res_q[comp_idx_1] <= comp_res_1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rt_flag_1   <= 1'b0;
      rt_flag_2   <= 1'b0;
      rt_index_1  <= '0;
      rt_index_2  <= '0;
      rt_result_1 <= '0;
      rt_result_2 <= '0;
      fp_i_1      <= '0;
      fp_i_2      <= '0;
      rt_store_1  <= 1'b0;
      rt_store_2  <= 1'b0;
    end else if (flush) begin
      rt_flag_1 <= 1'b0;
      rt_flag_2 <= 1'b0;
    end else begin
      rt_flag_1 <= ret_1;
      rt_flag_2 <= ret_2;
      if (ret_1) begin
        rt_index_1  <= rd_q[head];
        rt_result_1 <= res_q[head];
        fp_i_1      <= opd_q[head];
        rt_store_1  <= st_q[head];
      end
      if (ret_2) begin
        rt_index_2  <= rd_q[head_p1];
        rt_result_2 <= res_q[head_p1];
        fp_i_2      <= opd_q[head_p1];
        rt_store_2  <= st_q[head_p1];
      end
    end
  end

endmodule

// File: tb/tb_rob_ctrl.sv
// Directed self-checking bench for rob_ctrl: reset, in-order retire, full
// boundary, wrap-around, completion conflicts, flush, stores and reset.
module tb_rob_ctrl;

  localparam int PW = 6;

  logic          clk, rst, flush;
  logic          alloc_v_1, alloc_v_2, alloc_st_1, alloc_st_2;
  logic [PW-1:0] alloc_pd_1, alloc_pd_2, alloc_opd_1, alloc_opd_2;
  logic [4:0]    alloc_rd_1, alloc_rd_2;
  logic          alloc_ok;
  logic [3:0]    alloc_idx_1, alloc_idx_2;
  logic          comp_v_1, comp_v_2, comp_v_3;
  logic [3:0]    comp_idx_1, comp_idx_2, comp_idx_3;
  logic [31:0]   comp_res_1, comp_res_2, comp_res_3;
  logic          rt_flag_1, rt_flag_2, rt_store_1, rt_store_2;
  logic [4:0]    rt_index_1, rt_index_2;
  logic [31:0]   rt_result_1, rt_result_2;
  logic [PW-1:0] fp_i_1, fp_i_2;
  logic [4:0]    count;
  logic          full, empty;

  int errors = 0;
  int checks = 0;

  rob_ctrl #(.DEPTH(16), .PW(PW)) dut (
    .clk(clk), .rst(rst),
    .alloc_v_1(alloc_v_1), .alloc_v_2(alloc_v_2),
    .alloc_pd_1(alloc_pd_1), .alloc_pd_2(alloc_pd_2),
    .alloc_opd_1(alloc_opd_1), .alloc_opd_2(alloc_opd_2),
    .alloc_rd_1(alloc_rd_1), .alloc_rd_2(alloc_rd_2),
    .alloc_st_1(alloc_st_1), .alloc_st_2(alloc_st_2),
    .alloc_ok(alloc_ok), .alloc_idx_1(alloc_idx_1), .alloc_idx_2(alloc_idx_2),
    .comp_v_1(comp_v_1), .comp_v_2(comp_v_2), .comp_v_3(comp_v_3),
    .comp_idx_1(comp_idx_1), .comp_idx_2(comp_idx_2), .comp_idx_3(comp_idx_3),
    .comp_res_1(comp_res_1), .comp_res_2(comp_res_2), .comp_res_3(comp_res_3),
    .rt_flag_1(rt_flag_1), .rt_flag_2(rt_flag_2),
    .rt_index_1(rt_index_1), .rt_index_2(rt_index_2),
    .rt_result_1(rt_result_1), .rt_result_2(rt_result_2),
    .fp_i_1(fp_i_1), .fp_i_2(fp_i_2),
    .rt_store_1(rt_store_1), .rt_store_2(rt_store_2),
    .flush(flush), .count(count), .full(full), .empty(empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    flush = 1'b0;
    alloc_v_1 = 1'b0; alloc_v_2 = 1'b0; alloc_st_1 = 1'b0; alloc_st_2 = 1'b0;
    alloc_pd_1 = '0; alloc_pd_2 = '0; alloc_opd_1 = '0; alloc_opd_2 = '0;
    alloc_rd_1 = '0; alloc_rd_2 = '0;
    comp_v_1 = 1'b0; comp_v_2 = 1'b0; comp_v_3 = 1'b0;
    comp_idx_1 = '0; comp_idx_2 = '0; comp_idx_3 = '0;
    comp_res_1 = '0; comp_res_2 = '0; comp_res_3 = '0;
  endtask

  task automatic set_alloc1(input logic [4:0] rd, input logic [5:0] opd,
                            input logic [5:0] pd, input logic st);
    alloc_v_1 = 1'b1; alloc_rd_1 = rd; alloc_opd_1 = opd; alloc_pd_1 = pd; alloc_st_1 = st;
  endtask

  task automatic set_alloc2(input logic [4:0] rd, input logic [5:0] opd,
                            input logic [5:0] pd, input logic st);
    alloc_v_2 = 1'b1; alloc_rd_2 = rd; alloc_opd_2 = opd; alloc_pd_2 = pd; alloc_st_2 = st;
  endtask

  task automatic set_comp(input int port, input logic [3:0] idx, input logic [31:0] res);
    case (port)
      1: begin comp_v_1 = 1'b1; comp_idx_1 = idx; comp_res_1 = res; end
      2: begin comp_v_2 = 1'b1; comp_idx_2 = idx; comp_res_2 = res; end
      default: begin comp_v_3 = 1'b1; comp_idx_3 = idx; comp_res_3 = res; end
    endcase
  endtask

  initial begin
    idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
    // Reset state
    check("rst_count", 64'(count), 64'd0);
    check("rst_empty", 64'(empty), 64'd1);
    check("rst_full", 64'(full), 64'd0);
    check("rst_alloc_ok", 64'(alloc_ok), 64'd1);
    check("rst_idx1", 64'(alloc_idx_1), 64'd0);
    check("rst_idx2", 64'(alloc_idx_2), 64'd1);
    check("rst_rt_index_1", 64'(rt_index_1), 64'd0);
    check("rst_rt_result_2", 64'(rt_result_2), 64'd0);
    check("rst_fp_i_1", 64'(fp_i_1), 64'd0);
    check("rst_rt_store_1", 64'(rt_store_1), 64'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("idle_flag_1", 64'(rt_flag_1), 64'd0);
      check("idle_flag_2", 64'(rt_flag_2), 64'd0);
      check("idle_count", 64'(count), 64'd0);
    end

    // In-order retirement: index 1 completes before index 0
    set_alloc1(5'd1, 6'd1, 6'd33, 1'b0);
    set_alloc2(5'd2, 6'd2, 6'd34, 1'b0);
    #1;
    check("io_alloc_ok", 64'(alloc_ok), 64'd1);
    check("io_idx1", 64'(alloc_idx_1), 64'd0);
    check("io_idx2", 64'(alloc_idx_2), 64'd1);
    tick(); idle();
    check("io_count2", 64'(count), 64'd2);
    check("io_not_empty", 64'(empty), 64'd0);
    set_comp(2, 4'd1, 32'hAAAA);
    tick(); idle();
    check("io_no_early_retire_a", 64'(rt_flag_1), 64'd0);
    set_comp(1, 4'd0, 32'h5555);
    tick(); idle();
    check("io_no_early_retire_b", 64'(rt_flag_1), 64'd0);
    tick();
    check("io_flag_1", 64'(rt_flag_1), 64'd1);
    check("io_flag_2", 64'(rt_flag_2), 64'd1);
    check("io_index_1", 64'(rt_index_1), 64'd1);
    check("io_index_2", 64'(rt_index_2), 64'd2);
    check("io_result_1", 64'(rt_result_1), 64'h5555);
    check("io_result_2", 64'(rt_result_2), 64'hAAAA);
    check("io_fp_i_1", 64'(fp_i_1), 64'd1);
    check("io_fp_i_2", 64'(fp_i_2), 64'd2);
    check("io_store_1", 64'(rt_store_1), 64'd0);
    check("io_count0", 64'(count), 64'd0);
    tick();
    check("io_pulse_once", 64'(rt_flag_1), 64'd0);
    check("io_index_hold", 64'(rt_index_1), 64'd1);

    // Fill to 15 (head=tail=2): entry at index t gets rd=t, opd=t+16
    for (int k = 0; k < 7; k++) begin
      set_alloc1(5'(2 + 2*k), 6'(18 + 2*k), 6'(34 + 2*k), 1'b0);
      set_alloc2(5'(3 + 2*k), 6'(19 + 2*k), 6'(35 + 2*k), 1'b0);
      tick(); idle();
    end
    set_alloc1(5'd0, 6'd16, 6'd32, 1'b0);
    tick(); idle();
    check("fill_count15", 64'(count), 64'd15);
    check("fill_not_full", 64'(full), 64'd0);
    set_alloc1(5'd30, 6'd60, 6'd60, 1'b0);
    set_alloc2(5'd31, 6'd61, 6'd61, 1'b0);
    #1;
    check("aon_alloc_ok", 64'(alloc_ok), 64'd0);
    tick(); idle();
    check("aon_count_stays", 64'(count), 64'd15);
    set_alloc2(5'd1, 6'd17, 6'd33, 1'b0);
    #1;
    check("slot2_only_idx", 64'(alloc_idx_2), 64'd1);
    check("slot2_only_ok", 64'(alloc_ok), 64'd1);
    tick(); idle();
    check("full_count16", 64'(count), 64'd16);
    check("full_flag", 64'(full), 64'd1);
    set_comp(1, 4'd2, 32'h22);
    set_comp(2, 4'd3, 32'h33);
    tick(); idle();
    check("full_no_retire_yet", 64'(rt_flag_1), 64'd0);
    set_alloc1(5'd30, 6'd60, 6'd60, 1'b0);
    #1;
    check("full_retire_no_credit", 64'(alloc_ok), 64'd0);
    tick(); idle();
    check("full_count14", 64'(count), 64'd14);
    check("full_rt_flag_1", 64'(rt_flag_1), 64'd1);
    check("full_rt_flag_2", 64'(rt_flag_2), 64'd1);
    check("full_rt_index_1", 64'(rt_index_1), 64'd2);
    check("full_rt_index_2", 64'(rt_index_2), 64'd3);
    check("full_fp_i_1", 64'(fp_i_1), 64'd18);
    check("full_fp_i_2", 64'(fp_i_2), 64'd19);
    check("full_result_1", 64'(rt_result_1), 64'h22);
    flush = 1'b1;
    tick(); idle();
    check("flush1_count", 64'(count), 64'd0);
    check("flush1_empty", 64'(empty), 64'd1);

    // Offset pointers to 1 so a retiring pair straddles index 15 -> 0
    set_alloc1(5'd0, 6'd0, 6'd0, 1'b0);
    tick(); idle();
    set_comp(1, 4'd0, 32'd1);
    tick(); idle();
    tick();
    check("ofs_flag_1", 64'(rt_flag_1), 64'd1);
    check("ofs_flag_2", 64'(rt_flag_2), 64'd0);
    check("ofs_count", 64'(count), 64'd0);

    // Wrap-around: 40 entries, sequence s lands at index (s+1)%16
    for (int i = 0; i < 22; i++) begin
      if (i < 20) begin
        set_alloc1(5'((2*i) % 32), 6'((2*i + 5) % 64), 6'd0, 1'b0);
        set_alloc2(5'((2*i + 1) % 32), 6'((2*i + 6) % 64), 6'd0, 1'b0);
      end
      if (i >= 1 && i <= 20) begin
        set_comp(1, 4'((2*(i-1) + 1) % 16), 32'(2*(i-1)*3 + 1));
        set_comp(2, 4'((2*(i-1) + 2) % 16), 32'((2*(i-1) + 1)*3 + 1));
      end
      tick(); idle();
      check("wrap_count", 64'(count),
            64'(2*((i + 1 < 20) ? i + 1 : 20) - 2*((i > 1) ? i - 1 : 0)));
      if (i >= 2) begin
        check("wrap_flag_1", 64'(rt_flag_1), 64'd1);
        check("wrap_flag_2", 64'(rt_flag_2), 64'd1);
        check("wrap_index_1", 64'(rt_index_1), 64'((2*(i-2)) % 32));
        check("wrap_index_2", 64'(rt_index_2), 64'((2*(i-2) + 1) % 32));
        check("wrap_fp_i_1", 64'(fp_i_1), 64'((2*(i-2) + 5) % 64));
        check("wrap_fp_i_2", 64'(fp_i_2), 64'((2*(i-2) + 6) % 64));
        check("wrap_result_1", 64'(rt_result_1), 64'(2*(i-2)*3 + 1));
        check("wrap_result_2", 64'(rt_result_2), 64'((2*(i-2) + 1)*3 + 1));
      end else begin
        check("wrap_fill_flag", 64'(rt_flag_1), 64'd0);
      end
    end

    // Completion conflicts: ports 1 and 3 hit index 4; port 2 hits empty 12
    flush = 1'b1;
    tick(); idle();
    set_alloc1(5'd10, 6'd20, 6'd40, 1'b0);
    set_alloc2(5'd11, 6'd21, 6'd41, 1'b0);
    tick(); idle();
    set_alloc1(5'd12, 6'd22, 6'd42, 1'b0);
    set_alloc2(5'd13, 6'd23, 6'd43, 1'b0);
    tick(); idle();
    set_alloc1(5'd14, 6'd24, 6'd44, 1'b0);
    tick(); idle();
    check("cc_count5", 64'(count), 64'd5);
    set_comp(1, 4'd4, 32'd7);
    set_comp(3, 4'd4, 32'd9);
    set_comp(2, 4'd12, 32'hDEAD);
    tick(); idle();
    check("cc_count_unchanged", 64'(count), 64'd5);
    check("cc_no_retire_a", 64'(rt_flag_1), 64'd0);
    set_comp(1, 4'd0, 32'd100);
    set_comp(2, 4'd1, 32'd101);
    set_comp(3, 4'd2, 32'd102);
    tick(); idle();
    check("cc_no_retire_b", 64'(rt_flag_1), 64'd0);
    set_comp(1, 4'd3, 32'd103);
    tick(); idle();
    check("cc_r01_result_1", 64'(rt_result_1), 64'd100);
    check("cc_r01_result_2", 64'(rt_result_2), 64'd101);
    check("cc_r01_count", 64'(count), 64'd3);
    tick();
    check("cc_r23_flag_2", 64'(rt_flag_2), 64'd1);
    check("cc_r23_result_1", 64'(rt_result_1), 64'd102);
    check("cc_r23_result_2", 64'(rt_result_2), 64'd103);
    check("cc_r23_index_2", 64'(rt_index_2), 64'd13);
    tick();
    check("cc_r4_flag_1", 64'(rt_flag_1), 64'd1);
    check("cc_r4_flag_2", 64'(rt_flag_2), 64'd0);
    check("cc_r4_port1_wins", 64'(rt_result_1), 64'd7);
    check("cc_r4_index_1", 64'(rt_index_1), 64'd14);
    check("cc_r4_fp_i_1", 64'(fp_i_1), 64'd24);
    check("cc_r4_result_2_hold", 64'(rt_result_2), 64'd103);
    check("cc_r4_count", 64'(count), 64'd0);
    tick();
    check("cc_drained_flag", 64'(rt_flag_1), 64'd0);
    check("cc_drained_empty", 64'(empty), 64'd1);

    // Flush with 6 entries, head entry ready to retire at the flush edge
    flush = 1'b1;
    tick(); idle();
    for (int k = 0; k < 3; k++) begin
      set_alloc1(5'(20 + 2*k), 6'(30 + 2*k), 6'd0, 1'b0);
      set_alloc2(5'(21 + 2*k), 6'(31 + 2*k), 6'd0, 1'b0);
      tick(); idle();
    end
    check("fl_count6", 64'(count), 64'd6);
    set_comp(1, 4'd0, 32'h100);
    set_comp(2, 4'd2, 32'h200);
    set_comp(3, 4'd3, 32'h300);
    tick(); idle();
    check("fl_no_retire_yet", 64'(rt_flag_1), 64'd0);
    flush = 1'b1;
    set_alloc1(5'd5, 6'd5, 6'd5, 1'b0);
    set_comp(1, 4'd4, 32'h400);
    #1;
    check("fl_idx1_before", 64'(alloc_idx_1), 64'd6);
    check("fl_ok_ignores_flush", 64'(alloc_ok), 64'd1);
    tick(); idle();
    check("fl_count0", 64'(count), 64'd0);
    check("fl_flag_1", 64'(rt_flag_1), 64'd0);
    check("fl_flag_2", 64'(rt_flag_2), 64'd0);
    check("fl_idx1", 64'(alloc_idx_1), 64'd0);
    check("fl_empty", 64'(empty), 64'd1);
    set_comp(1, 4'd2, 32'hBAD);
    tick(); idle();
    check("fl_late_comp_count", 64'(count), 64'd0);
    check("fl_late_comp_flag", 64'(rt_flag_1), 64'd0);

    // Store entry retires with rt_store set
    set_alloc1(5'd7, 6'd9, 6'd40, 1'b1);
    set_alloc2(5'd8, 6'd10, 6'd41, 1'b0);
    tick(); idle();
    set_comp(1, 4'd0, 32'd0);
    set_comp(2, 4'd1, 32'h88);
    tick(); idle();
    tick();
    check("st_flag_1", 64'(rt_flag_1), 64'd1);
    check("st_store_1", 64'(rt_store_1), 64'd1);
    check("st_store_2", 64'(rt_store_2), 64'd0);
    check("st_index_1", 64'(rt_index_1), 64'd7);
    check("st_fp_i_1", 64'(fp_i_1), 64'd9);
    check("st_result_2", 64'(rt_result_2), 64'h88);

    // Reset clears the held retire outputs
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst2_store_1", 64'(rt_store_1), 64'd0);
    check("rst2_index_1", 64'(rt_index_1), 64'd0);
    check("rst2_result_2", 64'(rt_result_2), 64'd0);
    check("rst2_fp_i_1", 64'(fp_i_1), 64'd0);
    check("rst2_count", 64'(count), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rob_ctrl.md
# rob_ctrl

Re-order buffer controller for the out-of-order core. It owns the 16-entry circular ROB and its head/tail pointers, and allocates up to two entries per cycle for dispatch. It records completions from the three functional units by ROB index and retires up to two completed entries per cycle in program order to the rename stage (free list) and the architectural register file. It replaces flag-toggle sequencing with a clocked, pointer-based scheduler.

## Interface
- DEPTH, 16, ROB entries; power of two, pointer width = log2(DEPTH) = 4
- PW, 6, physical register index width
- clk  in  1  rising-edge clock
- rst  in  1  reset; synchronous and active-high
- alloc_v_1, alloc_v_2  in  1 each  dispatch slot valid; slot 1 is older
- alloc_pd_1, alloc_pd_2  in  PW each  new physical destination register
- alloc_opd_1, alloc_opd_2  in  PW each  previous physical register mapped to the destination
- alloc_rd_1, alloc_rd_2  in  5 each  architectural destination register
- alloc_st_1, alloc_st_2  in  1 each  entry is a store (SW); does no register write
- alloc_ok  out  1  combinational; free entries ≥ number of valid slots
- alloc_idx_1, alloc_idx_2  out  4 each  combinational; ROB index each valid slot will receive
- comp_v_k, k=1..3  in  1 each  FU k result valid
- comp_idx_k  in  4 each  ROB index of the FU k result
- comp_res_k  in  32 each  FU k result value
- rt_flag_1, rt_flag_2  out  1 each  registered; retire pulse
- rt_index_1, rt_index_2  out  5 each  architectural register to write
- rt_result_1, rt_result_2  out  32 each  value to write
- fp_i_1, fp_i_2  out  PW each  old physical register to free
- rt_store_1, rt_store_2  out  1 each  retired entry is a store; no register write
- flush  in  1  discard all entries
- count  out  5  registered; occupied entries, 0..16
- full, empty  out  1 each  count==16 and count==0

## Operation
- Each entry holds: v, comp, st, rd, pd, opd, result.
- Allocation:
  - Accepted only when alloc_ok=1. Acceptance is all-or-nothing: with 1 free entry and 2 valid slots, nothing is allocated.
  - Valid slots take consecutive entries starting at tail, in the order slot 1 then slot 2. If only slot 2 is valid, it takes tail.
  - Each accepted entry is written with v=1, comp=0 and the slot fields. tail advances by the number accepted, mod 16.
  - The free-entry count used for alloc_ok is 16 − count at the start of the cycle. Same-cycle retirements give no credit.
- Completion:
  - For each valid port whose target entry has v=1: set comp=1 and write result.
  - A completion to an entry with v=0 is ignored.
  - If two ports name the same index in one cycle, the lowest-numbered port wins.
  - Completing an entry that already has comp=1 overwrites result.
- Retirement uses state registered at the start of the cycle:
  - Slot 1 retires head if v=1 and comp=1.
  - Slot 2 retires head+1 (mod 16) only if slot 1 retired and head+1 has v=1 and comp=1.
  - A retired entry is cleared to v=0, comp=0. head advances by the number retired, mod 16.
  - Outputs for a non-retiring slot: rt_flag=0; the other rt_* outputs hold their last values.
- Count update: count_next = count + number allocated − number retired.
- Flush (priority over all other activity in the cycle):
  - All v and comp cleared; head=tail=0, count=0.
  - rt_flag_1 and rt_flag_2 are 0 on the next cycle.
  - Allocation, completion and retirement in the flush cycle are discarded.
- Reset has the same effect as flush. In addition, all rt_index/rt_result/fp_i/rt_store outputs are 0.

## Timing
- All state updates on the rising edge of clk.
- alloc_ok, alloc_idx, full and empty are combinational from registered state only. They do not depend on the comp_* inputs or on flush.
- Latencies:
  - Alloc at edge N → entry visible from edge N.
  - Completion may arrive in the cycle after edge N, i.e. at edge N+1 at the earliest.
  - Completion captured at edge M → rt_flag may be asserted from edge M+1.
  - Minimum alloc→retire latency: 2 cycles.
- rt_* outputs are registered and pulse for exactly one cycle per retired entry.
- Full boundary: with count=16, retiring 2 and requesting 2 allocations in the same cycle gives alloc_ok=0. count becomes 14 at the next edge.
- Wrap-around: pointers are 4 bits and roll from 15 to 0 with no special handling. Retiring entries 15 and 0 together is legal.
- Reset or flush asserted mid-operation takes effect at that edge. Any in-flight completion for a flushed index that arrives later is ignored because v=0.

## Test plan
- Reset then idle: count=0, empty=1, full=0, alloc_ok=1, alloc_idx_1=0, alloc_idx_2=1, and all rt_flag=0 for 5 cycles.
- In-order retire:
  - Allocate 2 entries (pd=33/34, opd=1/2, rd=1/2).
  - Complete index 1 (0xAAAA) one cycle before index 0 (0x5555).
  - Required: nothing retires before index 0 completes.
  - One cycle after index 0 completes: rt_flag_1=rt_flag_2=1, rt_index=1/2, rt_result=0x5555/0xAAAA, fp_i=1/2.
- Full and all-or-nothing:
  - Fill to 15 entries, then request 2: alloc_ok=0 and count stays 15.
  - Request 1: accepted, full=1.
  - Same cycle retire 2 plus request 1 while full: alloc_ok=0.
- Wrap-around: cycle 40 entries through the ROB. Retirement across indices 15→0 comes out in allocation order with correct fp_i, and count never exceeds 16.
- Completion conflicts:
  - comp_v_1 and comp_v_3 both set with idx=4 and results 7/9: entry 4 retires with 7.
  - Completion to an empty index 12: no state change.
- Flush:
  - With 6 entries, 3 completed, assert flush together with an allocation and a completion.
  - Next cycle: count=0, no retire pulse, alloc_idx_1=0.
  - A later completion to old index 2 is ignored.
  - A store entry (st=1) retires with rt_store=1.
